demux21_tdm: RTL and testbench
==============================

Name: demux21_tdm

Overview:
Receive-side counterpart of the 2-1 selector path. It takes a time-division-multiplexed word stream, in which channel-0 and channel-1 words alternate, and steers each word back to its own channel. Each channel output has a one-entry holding buffer with a valid/ready handshake. The block sits between the shared link and the two consumer blocks, and it reports sync and overflow errors.

Parameters:
W, 1, data word width in bits (1..32)

Ports:
CLK  input  1  system clock, rising-edge
RST_N  input  1  asynchronous active-low reset
DIN  input  W  multiplexed data word
VIN  input  1  DIN valid this cycle
SYNC  input  1  qualifies a VIN word as the channel-0 slot of a frame
Y0  output  W  channel-0 word
V0  output  1  Y0 valid
R0  input  1  channel-0 consumer ready
Y1  output  W  channel-1 word
V1  output  1  Y1 valid
R1  input  1  channel-1 consumer ready
S1  output  1  slot the next VIN word is expected in (0 = ch0, 1 = ch1)
SYNC_ERR  output  1  sticky: SYNC seen while S1 = 1
OVF  output  2  sticky per channel: word dropped because the buffer was full
CLR  input  1  synchronous clear of SYNC_ERR and OVF

Behaviour:
- Clock and reset: one clock, CLK. RST_N is asynchronous and active-low. While RST_N = 0, all outputs are 0: Y0, Y1, V0, V1, S1, SYNC_ERR and OVF.
- Slot tracking (state S1): captured on the rising edge of CLK when VIN = 1.
  - If SYNC = 1, the word is channel 0 and S1 becomes 1. This re-aligns the frame.
  - If SYNC = 0, the word goes to channel S1 and S1 toggles.
  - If VIN = 0, S1 holds and SYNC is ignored.
- Sync error: SYNC = 1 with VIN = 1 while S1 = 1 sets SYNC_ERR. The word is still treated as channel 0.
- Channel buffer k, states EMPTY and FULL (Vk = 1 exactly when FULL):
  - EMPTY, word arrives: load Yk, go FULL. Vk rises the cycle after capture (latency 1).
  - FULL, Rk = 1, no arrival: go EMPTY. Yk holds its last value.
  - FULL, Rk = 1, arrival same cycle: load the new word and stay FULL. This is pass-through at full rate.
  - FULL, Rk = 0, arrival: the word is dropped, Yk is unchanged and OVF[k] is set.
  - Yk is stable whenever Vk = 1 and Rk = 0.
- Rate: the two channels never receive in the same cycle. The sustained rate is one word per channel every 2 VIN cycles, with no stall when Rk is held at 1.
- CLR: clears SYNC_ERR and OVF on the next edge.
  - If a set event occurs in the same cycle as CLR, the set wins.
  - CLR does not affect the buffers or S1.
- Reset mid-operation: buffered words are discarded, and S1 returns to 0 (channel 0 is expected next).
- X-propagation: the handshake outputs (V0, V1, S1, OVF, SYNC_ERR) must never be X after reset. DIN is only sampled when VIN = 1.

Decomposition:
- Shared package/header holds:
  - the constants SLOT_CH0 = 0 and SLOT_CH1 = 1;
  - the buffer state encoding EMPTY = 0 and FULL = 1;
  - the OVF bit indices OVF_CH0 = 0 and OVF_CH1 = 1.
- One sub-module is natural: hold_buf, a W-bit one-entry valid/ready buffer with an overflow pulse. It is instantiated twice. The top level holds the slot logic and the sticky flags.

Test Plan:
- Reset: assert RST_N = 0 mid-stream -> all outputs are 0 immediately, without waiting for CLK; after release the first VIN word goes to channel 0.
- Alternation: R0 = R1 = 1; send VIN words A5, 3C, 0F, F0 (W = 8, SYNC with A5) -> Y0 = A5 then 0F, Y1 = 3C then F0, each Vk pulses one cycle after capture, OVF = 0.
- Backpressure: R0 = 0; send frames 11/22 and then 33/44 -> Y0 stays 11 with V0 = 1, 33 is dropped, OVF = 01, and Y1 passes 22 then 44.
- Sync realign: SYNC on the first word, then SYNC again on the 2nd word (S1 = 1) -> SYNC_ERR = 1, that word lands in Y0, and S1 = 1 afterwards.
- CLR precedence: pulse CLR in the same cycle as an overflow event -> OVF remains set; pulse CLR alone -> SYNC_ERR = 0 and OVF = 00 next cycle.
- Idle gaps: VIN is low for 3 cycles between the words of a pair -> S1 holds and pairing is unaffected.

Source files
------------

// File: rtl/demux21_tdm_pkg.sv
// Shared constants for the 2-1 TDM demultiplexer.
// Slot codes, buffer state encoding and OVF bit indices.
package demux21_tdm_pkg;

  localparam logic SLOT_CH0 = 1'b0;
  localparam logic SLOT_CH1 = 1'b1;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_e;

  localparam int OVF_CH0 = 0;
  localparam int OVF_CH1 = 1;

endpackage

// File: rtl/demux21_tdm_hold_buf.sv
// One-entry valid/ready holding buffer with a drop (overflow) pulse.
// Ports: clk, rst_n, din/load in; rdy in; dout/vld out; ovf pulse out.
module hold_buf
  import demux21_tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  input  logic         load,
  input  logic         rdy,
  output logic [W-1:0] dout,
  output logic         vld,
  output logic         ovf
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] data_q, data_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ovf     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (load) begin
          data_d  = din;
          state_d = FULL;
        end
      end
      FULL: begin
        // Consumer drains and refills in the same cycle.
        if (load && rdy) begin
          data_d = din;
        end else if (load) begin
          ovf = 1'b1;
        end else if (rdy) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  assign dout = data_q;
  assign vld  = (state_q == FULL);

endmodule

// File: rtl/demux21_tdm.sv
// Splits an alternating ch0/ch1 word stream into two buffered channels.
// Ports: CLK, RST_N, DIN/VIN/SYNC in; Y0/V0/R0, Y1/V1/R1; S1, SYNC_ERR, OVF, CLR.
module demux21_tdm
  import demux21_tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] DIN,
  input  logic         VIN,
  input  logic         SYNC,
  output logic [W-1:0] Y0,
  output logic         V0,
  input  logic         R0,
  output logic [W-1:0] Y1,
  output logic         V1,
  input  logic         R1,
  output logic         S1,
  output logic         SYNC_ERR,
  output logic [1:0]   OVF,
  input  logic         CLR
);

  logic       slot_q, slot_d;
  logic       sync_err_q, sync_err_d;
  logic [1:0] ovf_q, ovf_d;
  logic       load0, load1;
  logic       ovf0, ovf1;
  logic       sync_set;
  logic [1:0] ovf_set;

  // SYNC forces channel 0 regardless of the tracked slot.
  assign load0 = VIN && (SYNC || slot_q == SLOT_CH0);
  assign load1 = VIN && !SYNC && slot_q == SLOT_CH1;

  assign sync_set = VIN && SYNC && slot_q == SLOT_CH1;

  always_comb begin
    ovf_set          = 2'b00;
    ovf_set[OVF_CH0] = ovf0;
    ovf_set[OVF_CH1] = ovf1;
  end

  always_comb begin
    slot_d = slot_q;
    if (VIN) begin
      slot_d = SYNC ? SLOT_CH1 : ~slot_q;
    end
  end

  // Set wins over a same-cycle clear.
  always_comb begin
    sync_err_d = (sync_err_q && !CLR) || sync_set;
    ovf_d      = (ovf_q & {2{!CLR}}) | ovf_set;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      slot_q     <= SLOT_CH0;
      sync_err_q <= 1'b0;
      ovf_q      <= 2'b00;
    end else begin
      slot_q     <= slot_d;
      sync_err_q <= sync_err_d;
      ovf_q      <= ovf_d;
    end
  end

  hold_buf #(.W(W)) u_buf0 (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (DIN),
    .load  (load0),
    .rdy   (R0),
    .dout  (Y0),
    .vld   (V0),
    .ovf   (ovf0)
  );

  hold_buf #(.W(W)) u_buf1 (
    .clk   (CLK),
    .rst_n (RST_N),
    .din   (DIN),
    .load  (load1),
    .rdy   (R1),
    .dout  (Y1),
    .vld   (V1),
    .ovf   (ovf1)
  );

  assign S1       = slot_q;
  assign SYNC_ERR = sync_err_q;
  assign OVF      = ovf_q;

endmodule

// File: tb/tb_demux21_tdm.sv
// Directed self-checking bench for demux21_tdm (W = 8).
// obs packs {Y0,V0,Y1,V1,S1,SYNC_ERR,OVF}.
module tb_demux21_tdm;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [7:0] DIN;
  logic       VIN, SYNC, R0, R1, CLR;
  logic [7:0] Y0, Y1;
  logic       V0, V1, S1, SYNC_ERR;
  logic [1:0] OVF;

  int errors = 0;
  int checks = 0;

  demux21_tdm #(.W(8)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .DIN      (DIN),
    .VIN      (VIN),
    .SYNC     (SYNC),
    .Y0       (Y0),
    .V0       (V0),
    .R0       (R0),
    .Y1       (Y1),
    .V1       (V1),
    .R1       (R1),
    .S1       (S1),
    .SYNC_ERR (SYNC_ERR),
    .OVF      (OVF),
    .CLR      (CLR)
  );

  always #5 CLK = ~CLK;

  logic [21:0] obs;
  assign obs = {Y0, V0, Y1, V1, S1, SYNC_ERR, OVF};

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic s);
    DIN  = d;
    VIN  = 1'b1;
    SYNC = s;
    step();
    VIN  = 1'b0;
    SYNC = 1'b0;
    DIN  = 8'h00;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    DIN = 8'h00; VIN = 1'b0; SYNC = 1'b0;
    R0 = 1'b1; R1 = 1'b1; CLR = 1'b0;
    step();
    step();
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (obs !== 22'h0) begin
      errors++;
      $display("FAIL reset_state: got %h want %h", obs, 22'h0);
    end
    R0 = 1'b0;
    send(8'hA1, 1'b1);
    checks++;
    if (obs !== {8'hA1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL pre_reset_load: got %h", obs);
    end
    #3;
    RST_N = 1'b0;
    #1;
    checks++;
    if (obs !== 22'h0) begin
      errors++;
      $display("FAIL async_reset: got %h want %h", obs, 22'h0);
    end
    step();
    RST_N = 1'b1;
    R0 = 1'b1;
    send(8'hB2, 1'b0);
    checks++;
    if (obs !== {8'hB2, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL post_reset_ch0: got %h", obs);
    end
  endtask

  task automatic test_alternation();
    do_reset();
    send(8'hA5, 1'b1);
    checks++;
    if (obs !== {8'hA5, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL alt_w0: got %h", obs);
    end
    send(8'h3C, 1'b0);
    checks++;
    if (obs !== {8'hA5, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL alt_w1: got %h", obs);
    end
    send(8'h0F, 1'b0);
    checks++;
    if (obs !== {8'h0F, 1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL alt_w2: got %h", obs);
    end
    send(8'hF0, 1'b0);
    checks++;
    if (obs !== {8'h0F, 1'b0, 8'hF0, 1'b1, 1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL alt_w3: got %h", obs);
    end
    step();
    checks++;
    if (obs !== {8'h0F, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL alt_drain: got %h", obs);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    R0 = 1'b0;
    send(8'h11, 1'b1);
    send(8'h22, 1'b0);
    checks++;
    if (obs !== {8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL bp_pair1: got %h", obs);
    end
    send(8'h33, 1'b1);
    checks++;
    if (obs !== {8'h11, 1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 2'b01}) begin
      errors++;
      $display("FAIL bp_drop: got %h", obs);
    end
    send(8'h44, 1'b0);
    checks++;
    if (obs !== {8'h11, 1'b1, 8'h44, 1'b1, 1'b0, 1'b0, 2'b01}) begin
      errors++;
      $display("FAIL bp_pair2: got %h", obs);
    end
  endtask

  task automatic test_sync_realign();
    do_reset();
    send(8'h5A, 1'b1);
    send(8'hC3, 1'b1);
    checks++;
    if (obs !== {8'hC3, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL sync_err: got %h", obs);
    end
    send(8'h7E, 1'b0);
    checks++;
    if (obs !== {8'hC3, 1'b0, 8'h7E, 1'b1, 1'b0, 1'b1, 2'b00}) begin
      errors++;
      $display("FAIL sync_after: got %h", obs);
    end
  endtask

  task automatic test_clr();
    do_reset();
    R0 = 1'b0;
    send(8'h55, 1'b1);
    send(8'h66, 1'b1);
    checks++;
    if (obs !== {8'h55, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 2'b01}) begin
      errors++;
      $display("FAIL clr_setup: got %h", obs);
    end
    CLR = 1'b1;
    send(8'h77, 1'b1);
    CLR = 1'b0;
    checks++;
    if (obs !== {8'h55, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 2'b01}) begin
      errors++;
      $display("FAIL clr_set_wins: got %h", obs);
    end
    CLR = 1'b1;
    step();
    CLR = 1'b0;
    checks++;
    if (obs !== {8'h55, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL clr_alone: got %h", obs);
    end
  endtask

  task automatic test_idle_gaps();
    do_reset();
    send(8'h81, 1'b1);
    for (int i = 0; i < 3; i++) begin
      SYNC = 1'b1;
      DIN  = 8'hEE;
      step();
      checks++;
      if (S1 !== 1'b1 || SYNC_ERR !== 1'b0 || V1 !== 1'b0) begin
        errors++;
        $display("FAIL idle_hold%0d: S1=%b err=%b V1=%b want 1 0 0",
                 i, S1, SYNC_ERR, V1);
      end
    end
    SYNC = 1'b0;
    send(8'h82, 1'b0);
    checks++;
    if (obs !== {8'h81, 1'b0, 8'h82, 1'b1, 1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL idle_pair: got %h", obs);
    end
  endtask

  initial begin
    test_reset();
    test_alternation();
    test_backpressure();
    test_sync_realign();
    test_clr();
    test_idle_gaps();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
